// File: rtl/pipe_result_checker.sv
// pipe_result_checker
//
// Compares two result streams sample by sample: c_ref comes from the
// reference path (logic then pipe) and c_dut from the path under test
// (pipe then logic). After a start, the first WARMUP valid samples are
// discarded while the pipelines fill. The next NUM_CHECKS valid samples
// are compared. The block counts mismatches, captures the first failing
// sample, and reports a single done/pass status.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-low reset (0 = in reset)
//   start           begin a run; honoured only in IDLE or DONE
//   in_valid        c_ref/c_dut carry a sample this cycle
//   c_ref           reference-path result
//   c_dut           result of the path under test
//   busy            run in progress (WARMUP or COMPARE)
//   done            run finished (DONE)
//   pass            done with no mismatches
//   err_count       saturating mismatch count
//   check_count     samples compared in this run
//   mismatch_pulse  one-cycle pulse per mismatching compared sample
//   first_err_valid first-error capture registers hold data
//   first_err_idx   0-based compare index of the first mismatch
//   first_err_exp   c_ref at the first mismatch
//   first_err_act   c_dut at the first mismatch
//
// Timing: inputs are registered unconditionally (stage S1). The FSM and
// counters act on the S1 copy at the following edge (stage S2). A sample
// presented before edge E therefore shows on the outputs after edge E+1.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; samples ignored
// WARMUP  | discarding pipeline-fill samples
// COMPARE | comparing valid samples, counting mismatches
// DONE    | NUM_CHECKS samples compared; status held until start

module pipe_result_checker #(
  parameter int WIDTH       = 16,
  parameter int PIPE_STAGES = 3,
  parameter int WARMUP      = 2 * PIPE_STAGES,
  parameter int NUM_CHECKS  = 94,
  parameter int CNT_W       = 16,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] c_ref,
  input  logic [WIDTH-1:0] c_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] check_count,
  output logic             mismatch_pulse,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_act
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WARMUP_C = CNT_W'(WARMUP);
  localparam logic [CNT_W-1:0] NUM_C    = CNT_W'(NUM_CHECKS);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  state_t           state;
  logic [CNT_W-1:0] warm_cnt;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_ref;
  logic [WIDTH-1:0] s1_dut;
  logic             s1_mismatch;

  // Stage S1: plain input register. There is no gating, so the compare
  // always sees a clean, registered pair whatever the FSM is doing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_ref   <= '0;
      s1_dut   <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_ref   <= c_ref;
      s1_dut   <= c_dut;
    end
  end

  // Case inequality: an X/Z bit in either operand in simulation counts as
  // a failure rather than silently matching. Synthesis treats it as !=.
  assign s1_mismatch = (s1_ref !== s1_dut);

  // Stage S2: FSM, counters and first-error capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      warm_cnt        <= '0;
      err_count       <= '0;
      check_count     <= '0;
      mismatch_pulse  <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_exp   <= '0;
      first_err_act   <= '0;
    end else begin
      mismatch_pulse <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            warm_cnt        <= '0;
            err_count       <= '0;
            check_count     <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_exp   <= '0;
            first_err_act   <= '0;
            state           <= (WARMUP == 0) ? ST_COMPARE : ST_WARMUP;
          end
        end

        ST_WARMUP: begin
          if (s1_valid) begin
            warm_cnt <= warm_cnt + CNT_ONE;
            if (warm_cnt + CNT_ONE == WARMUP_C) begin
              state <= ST_COMPARE;
            end
          end
        end

        ST_COMPARE: begin
          if (s1_valid) begin
            check_count <= check_count + CNT_ONE;
            if (s1_mismatch) begin
              mismatch_pulse <= 1'b1;
              if (err_count != ERR_MAX) begin
                err_count <= err_count + ERR_ONE;
              end
              // The index is the pre-increment count, i.e. 0-based.
              if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_idx   <= check_count;
                first_err_exp   <= s1_ref;
                first_err_act   <= s1_dut;
              end
            end
            if (check_count + CNT_ONE == NUM_C) begin
              state <= ST_DONE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decoded from the state register, so these change only on clock edges.
  assign busy = (state == ST_WARMUP) || (state == ST_COMPARE);
  assign done = (state == ST_DONE);
  // done is registered, so pass cannot rise before the run is complete.
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_pipe_result_checker.sv
module tb_pipe_result_checker;

  localparam int WIDTH      = 16;
  localparam int WARMUP     = 6;
  localparam int NUM_CHECKS = 94;
  localparam int CNT_W      = 16;
  localparam int ERR_W      = 8;
  localparam int ERR_MAX    = 255;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic in_valid = 1'b0;
  logic [WIDTH-1:0] c_ref = '0;
  logic [WIDTH-1:0] c_dut = '0;

  logic             busy, done, pass, mismatch_pulse, first_err_valid;
  logic [ERR_W-1:0] err_count;
  logic [CNT_W-1:0] check_count, first_err_idx;
  logic [WIDTH-1:0] first_err_exp, first_err_act;

  logic             b2, d2, p2, mp2, fv2;
  logic [2:0]       e2;
  logic [CNT_W-1:0] cc2, fi2;
  logic [WIDTH-1:0] fe2, fa2;

  always #5 clk = ~clk;

  pipe_result_checker #(
    .WIDTH(WIDTH), .PIPE_STAGES(3), .WARMUP(WARMUP), .NUM_CHECKS(NUM_CHECKS),
    .CNT_W(CNT_W), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .c_ref(c_ref), .c_dut(c_dut), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .check_count(check_count),
    .mismatch_pulse(mismatch_pulse), .first_err_valid(first_err_valid),
    .first_err_idx(first_err_idx), .first_err_exp(first_err_exp),
    .first_err_act(first_err_act)
  );

  // Small-counter variant used for the saturation test.
  pipe_result_checker #(
    .WIDTH(WIDTH), .PIPE_STAGES(3), .WARMUP(0), .NUM_CHECKS(12),
    .CNT_W(CNT_W), .ERR_W(3)
  ) dut_sat (
    .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid),
    .c_ref(c_ref), .c_dut(c_dut), .busy(b2), .done(d2), .pass(p2),
    .err_count(e2), .check_count(cc2),
    .mismatch_pulse(mp2), .first_err_valid(fv2),
    .first_err_idx(fi2), .first_err_exp(fe2),
    .first_err_act(fa2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt  = 0;
  int pulse2_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected status derived from the run rules: after start, count valid
  // samples; those beyond WARMUP are compared until NUM_CHECKS have been.
  // The model sees each sample one edge after it is presented.
  bit               m_run, m_done, m_pulse, m_fv;
  int               m_seen, m_chk, m_err, m_fidx;
  logic [WIDTH-1:0] m_fexp, m_fact;
  bit               d_valid;
  logic [WIDTH-1:0] d_ref, d_dut;

  task automatic model_clear();
    m_run = 0; m_done = 0; m_pulse = 0; m_fv = 0;
    m_seen = 0; m_chk = 0; m_err = 0; m_fidx = 0;
    m_fexp = '0; m_fact = '0;
    d_valid = 0; d_ref = '0; d_dut = '0;
  endtask

  task automatic model_edge();
    int idx;
    m_pulse = 0;
    if (!m_run) begin
      if (start) begin
        m_run = 1; m_done = 0; m_seen = 0; m_chk = 0; m_err = 0;
        m_fv = 0; m_fidx = 0; m_fexp = '0; m_fact = '0;
      end
    end else if (d_valid) begin
      m_seen++;
      if (m_seen > WARMUP) begin
        idx   = m_seen - WARMUP - 1;
        m_chk = idx + 1;
        if (d_ref !== d_dut) begin
          m_pulse = 1;
          if (m_err < ERR_MAX) m_err++;
          if (!m_fv) begin
            m_fv = 1; m_fidx = idx; m_fexp = d_ref; m_fact = d_dut;
          end
        end
        if (m_chk == NUM_CHECKS) begin
          m_run = 0; m_done = 1;
        end
      end
    end
    d_valid = in_valid; d_ref = c_ref; d_dut = c_dut;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_clear();
      else model_edge();
    end
  end

  // Compare process: every negedge out of reset.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check("busy", busy, m_run);
        check("done", done, m_done);
        check("pass", pass, (m_done && m_err == 0));
        check("err_count", err_count, m_err);
        check("check_count", check_count, m_chk);
        check("mismatch_pulse", mismatch_pulse, m_pulse);
        check("first_err_valid", first_err_valid, m_fv);
        check("first_err_idx", first_err_idx, m_fidx);
        check("first_err_exp", first_err_exp, m_fexp);
        check("first_err_act", first_err_act, m_fact);
        if (mismatch_pulse) pulse_cnt++;
        if (mp2) pulse2_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic begin_run();
    step();
    start = 1'b1;
    in_valid = 1'b0;
  endtask

  // Drives n_cyc cycles. Valid samples are numbered v; samples with v in
  // [bad_lo,bad_hi] get bit 0 flipped, v==special gets 1234/1235, and
  // start is raised during cycle start_at. Bubble cycles carry garbage.
  task automatic run_stream(input int n_cyc, input bit bubbles, input int bad_lo,
                            input int bad_hi, input int special, input int start_at);
    int v;
    logic [WIDTH-1:0] r;
    v = 0;
    for (int i = 0; i < n_cyc; i++) begin
      step();
      start = (i == start_at);
      r = WIDTH'($urandom);
      if (bubbles && (i % 2 == 1)) begin
        in_valid = 1'b0;
        c_ref = r;
        c_dut = ~r;
      end else begin
        in_valid = 1'b1;
        c_ref = r;
        c_dut = (v >= bad_lo && v <= bad_hi) ? (r ^ 16'h0001) : r;
        if (v == special) begin
          c_ref = 16'h1234;
          c_dut = 16'h1235;
        end
        v++;
      end
    end
    step();
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 20 && !done; k++) @(negedge clk);
    check(name, done, 1);
  endtask

  initial begin
    // Reset held for 3 cycles.
    repeat (3) step();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_count, 0);
    check("rst_fv", first_err_valid, 0);
    step();
    reset = 1'b1;

    // 1. Clean run.
    pulse_cnt = 0;
    begin_run();
    run_stream(100, 0, -1, -1, -1, -1);
    @(negedge clk);
    check("t1_done_not_yet", done, 0);
    @(negedge clk);
    check("t1_done_rise", done, 1);
    check("t1_check_count", check_count, 94);
    check("t1_err", err_count, 0);
    check("t1_pass", pass, 1);
    check("t1_fv", first_err_valid, 0);
    check("t1_pulses", pulse_cnt, 0);

    // 2. Warm-up immunity.
    pulse_cnt = 0;
    begin_run();
    run_stream(100, 0, 0, 5, -1, -1);
    wait_done("t2_done");
    check("t2_err", err_count, 0);
    check("t2_pass", pass, 1);
    check("t2_pulses", pulse_cnt, 0);

    // 3. Single mismatch at compare index 10 (valid sample 16).
    pulse_cnt = 0;
    begin_run();
    run_stream(100, 0, -1, -1, 16, -1);
    wait_done("t3_done");
    check("t3_err", err_count, 1);
    check("t3_fidx", first_err_idx, 10);
    check("t3_fexp", first_err_exp, 16'h1234);
    check("t3_fact", first_err_act, 16'h1235);
    check("t3_pulses", pulse_cnt, 1);
    check("t3_pass", pass, 0);

    // 4. Bubbles.
    begin_run();
    run_stream(200, 1, -1, -1, -1, -1);
    wait_done("t4_done");
    check("t4_check_count", check_count, 94);
    check("t4_pass", pass, 1);

    // 5. Saturation on the ERR_W=3 / WARMUP=0 / NUM_CHECKS=12 instance.
    pulse2_cnt = 0;
    step();
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    run_stream(14, 0, 0, 13, -1, -1);
    for (int k = 0; k < 20 && !d2; k++) @(negedge clk);
    check("t5_done", d2, 1);
    check("t5_err_sat", e2, 7);
    check("t5_check_count", cc2, 12);
    check("t5_fidx", fi2, 0);
    check("t5_fv", fv2, 1);
    check("t5_pass", p2, 0);
    check("t5_pulses", pulse2_cnt, 12);

    // 6. Mismatch at compare index 3, ignored start mid-COMPARE, async reset.
    begin_run();
    run_stream(47, 0, 9, 9, -1, 26);
    @(negedge clk);
    check("t6_busy", busy, 1);
    check("t6_err", err_count, 1);
    check("t6_fidx", first_err_idx, 3);
    check("t6_fv", first_err_valid, 1);
    #1;
    reset = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_pass", pass, 0);
    check("t6_rst_err", err_count, 0);
    check("t6_rst_cc", check_count, 0);
    check("t6_rst_pulse", mismatch_pulse, 0);
    check("t6_rst_fv", first_err_valid, 0);
    check("t6_rst_fidx", first_err_idx, 0);
    check("t6_rst_fexp", first_err_exp, 0);
    check("t6_rst_fact", first_err_act, 0);
    repeat (2) step();
    reset = 1'b1;

    begin_run();
    run_stream(100, 0, -1, -1, -1, -1);
    wait_done("t6_run2_done");
    check("t6_run2_pass", pass, 1);
    check("t6_run2_fv", first_err_valid, 0);
    check("t6_run2_cc", check_count, 94);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_result_checker.md
Name: pipe_result_checker

Overview:
- Synthesizable downstream checker that takes the two result streams of a pipelined arithmetic pair: the reference path (logic then pipe) and the path under test (pipe then logic).
- Discards the pipeline-fill warm-up samples, then compares a fixed number of valid samples.
- Counts mismatches and captures the first failing sample.
- Reports done/pass, so a bench or on-chip self-test can read one status instead of printing per-cycle logs.

Parameters:
- WIDTH, 16, result data width (8..32).
- PIPE_STAGES, 3, pipeline depth of the paths being checked. Informational only; it sets the WARMUP default.
- WARMUP, 2*PIPE_STAGES, number of valid samples discarded after start (0 allowed).
- NUM_CHECKS, 94, number of valid samples compared per run (1..2^CNT_W-1).
- CNT_W, 16, width of check counter and index outputs.
- ERR_W, 8, width of the mismatch counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  begin a run; honoured only in IDLE or DONE.
- in_valid  in  1  c_ref/c_dut hold a sample this cycle.
- c_ref  in  WIDTH  reference-path result.
- c_dut  in  WIDTH  result of the path under test.
- busy  out  1  state is WARMUP or COMPARE.
- done  out  1  state is DONE.
- pass  out  1  done and err_count==0.
- err_count  out  ERR_W  saturating mismatch count.
- check_count  out  CNT_W  samples compared this run.
- mismatch_pulse  out  1  one-cycle pulse per mismatching compared sample.
- first_err_valid  out  1  first-error capture registers hold data.
- first_err_idx  out  CNT_W  compare index (0-based) of the first mismatch.
- first_err_exp  out  WIDTH  c_ref at the first mismatch.
- first_err_act  out  WIDTH  c_dut at the first mismatch.

Behaviour:
- Reset (async, reset==0):
  - State goes to IDLE.
  - All outputs and internal registers go to 0.
  - Applies from any state, mid-run included; the partial run is lost.
- Input stage:
  - in_valid, c_ref and c_dut are registered every cycle (stage S1), with no gating.
  - Counters, FSM and status update on the next edge (stage S2).
  - Latency: a sample presented before edge E affects outputs right after edge E+1.
- FSM states: IDLE, WARMUP, COMPARE, DONE.
  - IDLE: on start, clear err_count, check_count, first_err_*, warm-up counter and mismatch_pulse. Go to WARMUP, or to COMPARE directly if WARMUP==0.
  - WARMUP: each S1-valid sample increments the warm-up counter. The sample that makes it equal WARMUP moves the FSM to COMPARE. Warm-up samples are never compared.
  - COMPARE: each S1-valid sample is compared and check_count increments.
    - A mismatch uses case-inequality semantics: any X/Z bit in either operand counts as a mismatch.
    - On mismatch: err_count increments, saturating at 2^ERR_W-1, and mismatch_pulse is high for one cycle.
    - If first_err_valid==0, capture the index (check_count value before increment), exp and act, and set first_err_valid.
    - The sample that makes check_count equal NUM_CHECKS moves the FSM to DONE on the same edge.
  - DONE: status holds stable. in_valid is ignored. start re-enters the IDLE clearing and launches a new run on the same edge.
- start while busy is ignored. Samples in IDLE or DONE are ignored.
- in_valid gaps (bubbles) stall counting only; there is no timeout.
- mismatch_pulse is 0 in every state except the cycle after a mismatching compare.
- pass is combinational from registered done and err_count, so it never glitches high before done.

Test Plan:
1. Clean run:
   - Stimulus: reset low 3 cycles, release, pulse start, then 100 consecutive valid samples with c_ref==c_dut (random, WIDTH=16).
   - Required: done rises 2 edges after the 100th sample; check_count=94, err_count=0, pass=1, first_err_valid=0, mismatch_pulse never high.
2. Warm-up immunity:
   - Stimulus: samples 0..5 have c_dut=c_ref^16'h0001, samples 6..99 match.
   - Required: err_count=0, pass=1.
3. Single mismatch:
   - Stimulus: compare index 10 has c_ref=16'h1234, c_dut=16'h1235, all others match.
   - Required: err_count=1; first_err_idx=10, exp=16'h1234, act=16'h1235; exactly one mismatch_pulse cycle; pass=0 at done.
4. Bubbles:
   - Stimulus: in_valid alternates 1/0 for 200 cycles, all matching.
   - Required: done after the 100th valid sample, not before; check_count=94.
5. Saturation:
   - Stimulus: ERR_W=3, WARMUP=0, NUM_CHECKS=12, every sample mismatches.
   - Required: err_count stops at 7; check_count=12; first_err_idx=0.
6. Reset and restart:
   - Stimulus: run 1 injects a mismatch at compare index 3; start is pulsed mid-COMPARE; reset is dropped at compare index 40.
   - Required: the mid-COMPARE start is ignored; the reset clears every output to 0 immediately (asynchronously).
   - Stimulus: run 2 is a clean restart.
   - Required: pass=1, first_err_valid=0.
